// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared helpers for the stall-everything valid/ready pipelines.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    // Pointer width: index bits plus one wrap bit.
    function automatic int PTR_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// Elaboration-time guard; expands to a labelled generate-if at module scope.
`define PIPELINE_CHECK_DEPTH(D) \
    if (!pipeline_pkg::depth_ok(D)) begin : g_bad_depth \
        $error("DEPTH must be a power of two and at least 2"); \
    end

`default_nettype wire

// File: rtl/pipeline_ready_fifo.sv
// ============================================================================
//  Module   : pipeline_ready_fifo
//  Purpose  : Fully registered receive FIFO that cuts the combinational ready
//             chain of a stall-everything pipeline at one beat per cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ready_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    u_data,
    input  logic                     u_valid,
    output logic                     u_ready,
    output logic [DATA_WIDTH-1:0]    d_data,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = PTR_W(DEPTH);

    `PIPELINE_CHECK_DEPTH(DEPTH)

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  u_ready_q, u_ready_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr;
    logic                  rd;

    always_comb begin
        wr       = u_valid && u_ready_q;
        rd       = d_valid_q && d_ready;
        wr_ptr_d = wr_ptr_q + PW'(wr);
        rd_ptr_d = rd_ptr_q + PW'(rd);
        // Wrap-bit pointer difference is count + wr - rd, spanning 0..DEPTH.
        count_d   = wr_ptr_d - rd_ptr_d;
        u_ready_d = (count_d != PW'(DEPTH));
        d_valid_d = (count_d != '0);
        mem_d     = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q[PW-2:0]] = u_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            u_ready_q <= 1'b1;
            d_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            u_ready_q <= u_ready_d;
            d_valid_q <= d_valid_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign u_ready = u_ready_q;
    assign d_valid = d_valid_q;
    assign count   = count_q;
    assign d_data  = mem_q[rd_ptr_q[PW-2:0]];

endmodule

`default_nettype wire

// File: doc/pipeline_ready_fifo.md
# pipeline_ready_fifo

Registered-handshake receive buffer for the valid/ready stage interface used by the stall-everything pipelines, whose upstream ready is a combinational copy of downstream ready. It sits on the downstream end of such a pipeline and absorbs its output beats into a DEPTH-entry FIFO. Every output, including `u_ready`, is driven from flops, which cuts the long ready chain at the pipeline boundary. It still sustains one beat per cycle.

## Interface
- `DATA_WIDTH`, default 32: payload width.
- `DEPTH`, default 4: number of storage entries; must be a power of two, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `u_data`  in  DATA_WIDTH  upstream payload.
- `u_valid`  in  1  upstream beat valid.
- `u_ready`  out  1  buffer can accept; registered.
- `d_data`  out  DATA_WIDTH  head-of-FIFO payload.
- `d_valid`  out  1  head entry valid; registered.
- `d_ready`  in  1  downstream accepts head.
- `count`  out  $clog2(DEPTH)+1  occupied entries, range 0..DEPTH; registered.

## Operation
- Write (`wr`) happens when `u_valid && u_ready`. The beat is stored at `wr_ptr` and `wr_ptr` increments.
- Read (`rd`) happens when `d_valid && d_ready`. `rd_ptr` increments.
- Pointers are $clog2(DEPTH)+1 bits wide, and the extra bit marks wrap.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSB differs.
- `next_count` = `count` + `wr` − `rd`.
- Registered flags, all updated every cycle:
  - `count` ← `next_count`
  - `u_ready` ← (`next_count` != DEPTH)
  - `d_valid` ← (`next_count` != 0)
- `d_data` = storage[`rd_ptr` low bits]. It is a mux of storage flops, so there is no combinational path from any input.
- Storage holds its value when it is not written. Storage is not reset; only the pointers and flags are.
- No state machine: the state is fully described by `count` and the two pointers.
- Beats are never dropped, duplicated or reordered.
- `u_valid` while `u_ready`=0 has no effect.
- `d_ready` while `d_valid`=0 has no effect.

## Timing
- Reset values:
  - `u_ready`=1
  - `d_valid`=0
  - `count`=0
  - pointers = 0
  - `d_data` is don't-care while `d_valid`=0.
- Latency: a beat accepted at edge N is presented with `d_valid`=1 after edge N, meaning it is visible in cycle N+1.
- Full (`count`=DEPTH): `u_ready`=0.
  - A read in a full cycle raises `u_ready` in the next cycle.
  - No same-cycle pass-through.
- Empty: `d_valid`=0.
  - A write raises `d_valid` in the next cycle.
- Simultaneous wr and rd: `count` is unchanged and both pointers advance.
  - At `count`=1 this gives throughput 1 beat/cycle, with `d_data` switching to the new beat.
- Pointer wrap: at DEPTH−1 the low bits wrap to 0 and the MSB toggles. Full/empty detection stays correct across any number of wraps.
- Reset asserted mid-operation: all contents are discarded immediately and the reset values apply asynchronously. The first cycle after deassertion behaves as empty.
- Sustained rate:
  - 1 beat/cycle in both directions when `d_ready` stays high.
  - While `d_ready`=0, DEPTH beats are accepted before `u_ready` drops.

## Structure
- Shared package `pipeline_pkg`:
  - `PTR_W(depth)` function (= $clog2(depth)+1).
  - Parameter-check macro enforcing power-of-two DEPTH ≥2 (elaboration error otherwise).
- Single module. No sub-module is needed; storage is an inline register array.
- Intended composition: `pipeline_4stage` d_* → `pipeline_ready_fifo` u_*. The flopped `u_ready` then drives the pipeline's `d_ready`.

## Test plan
- Reset, then 10 idle cycles → `u_ready`=1, `d_valid`=0, `count`=0. Assert `rst_n` low mid-cycle → outputs return to reset values without waiting for a clock edge.
- `d_ready`=1, push 0x00000001..0x00000010 back-to-back:
  - each value appears on `d_data` exactly one cycle after acceptance, in order;
  - `count` ≤1;
  - `u_ready` never drops.
- `d_ready`=0, push 0xA0..0xA5 continuously:
  - 4 beats accepted, `count`=4, `u_ready`=0 from the cycle after the 4th write;
  - 0xA4 is held on `u_data` until space frees;
  - `d_data`=0xA0.
- From full, single `d_ready` pulse → 0xA0 read, `count`=3, `u_ready`=1 the next cycle, 0xA4 accepted.
- 3×DEPTH+1 beats with randomized `u_valid`/`d_ready` (seeded) → scoreboard matches in order; pointers wrap at least 3 times; no overflow or underflow.
- `count`=1 with simultaneous wr 0x55 and rd → `count` stays 1, `d_valid` stays 1, `d_data`=0x55 the next cycle.
